// File: rtl/float_addsub_stream.sv
// Streaming floating-point add/subtract model: three-way AXI-Stream join, elastic pipeline, result on the last stage.
// Optional status flags on m_axis_result_flags when FLOAT_ADDSUB_STREAM_FLAGS_EN is defined.
module float_addsub_stream #(
    parameter int SIZE    = 32,
    parameter int LATENCY = 12,
    parameter int USER_W  = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [SIZE-1:0]   s_axis_a_tdata,
    input  logic [USER_W-1:0] s_axis_a_tuser,
    input  logic              s_axis_a_tvalid,
    output logic              s_axis_a_tready,
    input  logic [SIZE-1:0]   s_axis_b_tdata,
    input  logic              s_axis_b_tvalid,
    output logic              s_axis_b_tready,
    input  logic [7:0]        s_axis_operation_tdata,
    input  logic              s_axis_operation_tvalid,
    output logic              s_axis_operation_tready,
    output logic [SIZE-1:0]   m_axis_result_tdata,
    output logic [USER_W-1:0] m_axis_result_tuser,
`ifdef FLOAT_ADDSUB_STREAM_FLAGS_EN
    output logic [2:0]        m_axis_result_flags,
`endif
    output logic              m_axis_result_tvalid,
    input  logic              m_axis_result_tready
);

    localparam int LAST = LATENCY - 1;

    generate
        if (SIZE != 32 && SIZE != 64) begin : g_bad_size
            $fatal(1, "float_addsub_stream: SIZE must be 32 or 64");
        end
        if (LATENCY < 1 || LATENCY > 64) begin : g_bad_latency
            $fatal(1, "float_addsub_stream: LATENCY must be 1..64");
        end
    endgenerate

    logic [LATENCY-1:0] stg_valid;
    logic [LATENCY-1:0] stg_load;
    logic [LATENCY-1:0] stg_sub;
    logic [SIZE-1:0]    stg_a    [LATENCY];
    logic [SIZE-1:0]    stg_b    [LATENCY];
    logic [USER_W-1:0]  stg_user [LATENCY];
    logic               all_valid;
    logic               accept;
    logic               unused_op_bits;

    // Single-precision operand widened exactly into a double.
    function automatic real sp_to_real(input logic [31:0] x);
        logic [63:0] d;
        int p;
        d     = '0;
        d[63] = x[31];
        p     = 0;
        if (x[30:23] == 8'hFF) begin
            d[62:52] = '1;
            d[51:29] = x[22:0];
            if (x[22:0] != '0) d[51] = 1'b1;
        end else if (x[30:23] != 8'h00) begin
            d[62:52] = 11'(int'(x[30:23]) + 896);
            d[51:29] = x[22:0];
        end else if (x[22:0] != '0) begin
            for (int i = 0; i < 23; i++) if (x[i]) p = i;
            d[62:52] = 11'(p + 874);
            d[51:0]  = 52'(x[22:0]) << (52 - p);
        end
        return $bitstoreal(d);
    endfunction

    // Double narrowed to single with round-to-nearest-even, including the subnormal range.
    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        logic [63:0] m;
        logic [63:0] q;
        logic [31:0] base;
        logic        s;
        logic        rnd;
        logic        sticky;
        int          ex;
        int          sh;
        d = $realtobits(r);
        s = d[63];
        m = {11'b0, 1'b1, d[51:0]};
        if (d[62:52] == 11'h7FF) return (d[51:0] != '0) ? 32'h7FC0_0000 : {s, 8'hFF, 23'b0};
        if (d[62:52] == 11'h000) return {s, 31'b0};
        ex = int'(d[62:52]) - 1023;
        if (ex > 127) return {s, 8'hFF, 23'b0};
        if (ex >= -126) begin
            // A carry out of the fraction rolls into the exponent, reaching infinity at the top.
            base   = {s, 8'(ex + 127), m[51:29]};
            rnd    = m[28];
            sticky = |m[27:0];
            return base + 32'(rnd & (sticky | m[29]));
        end
        sh = -(ex + 97);
        if (sh > 53) return {s, 31'b0};
        q      = m >> sh;
        rnd    = m[sh-1];
        sticky = |(m & ((64'd1 << (sh - 1)) - 64'd1));
        q      = q + 64'(rnd & (sticky | q[0]));
        return {s, q[30:0]};
    endfunction

    function automatic logic [31:0] sp_addsub(input logic [31:0] a, input logic [31:0] b, input logic sub);
        real ra;
        real rb;
        ra = sp_to_real(a);
        rb = sp_to_real(b);
        return real_to_sp(sub ? (ra - rb) : (ra + rb));
    endfunction

    function automatic logic [63:0] dp_addsub(input logic [63:0] a, input logic [63:0] b, input logic sub);
        logic [63:0] d;
        d = $realtobits(sub ? ($bitstoreal(a) - $bitstoreal(b)) : ($bitstoreal(a) + $bitstoreal(b)));
        if (d[62:52] == 11'h7FF && d[51:0] != '0) return 64'h7FF8_0000_0000_0000;
        return d;
    endfunction

    function automatic logic [LATENCY-1:0] low_mask(input int k);
        return (LATENCY'(1) << k) - LATENCY'(1);
    endfunction

    // Stage k may load unless it and every stage after it are full while the output is stalled.
    always_comb begin
        stg_load = '0;
        for (int k = 0; k < LATENCY; k++) begin
            stg_load[k] = m_axis_result_tready | ~&(stg_valid | low_mask(k));
        end
    end

    assign all_valid               = s_axis_a_tvalid & s_axis_b_tvalid & s_axis_operation_tvalid;
    assign accept                  = aresetn & stg_load[0] & all_valid;
    assign s_axis_a_tready         = accept;
    assign s_axis_b_tready         = accept;
    assign s_axis_operation_tready = accept;
    assign unused_op_bits          = ^s_axis_operation_tdata[7:1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stg_valid <= '0;
        end else begin
            if (stg_load[0]) stg_valid[0] <= accept;
            for (int k = 1; k < LATENCY; k++) begin
                if (stg_load[k]) stg_valid[k] <= stg_valid[k-1];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (accept) begin
            stg_a[0]    <= s_axis_a_tdata;
            stg_b[0]    <= s_axis_b_tdata;
            stg_sub[0]  <= s_axis_operation_tdata[0];
            stg_user[0] <= s_axis_a_tuser;
        end
        for (int k = 1; k < LATENCY; k++) begin
            if (stg_load[k] && stg_valid[k-1]) begin
                stg_a[k]    <= stg_a[k-1];
                stg_b[k]    <= stg_b[k-1];
                stg_sub[k]  <= stg_sub[k-1];
                stg_user[k] <= stg_user[k-1];
            end
        end
    end

    assign m_axis_result_tvalid = stg_valid[LAST];
    assign m_axis_result_tuser  = stg_user[LAST];

    generate
        if (SIZE == 32) begin : g_single
            always_comb m_axis_result_tdata = sp_addsub(stg_a[LAST], stg_b[LAST], stg_sub[LAST]);
        end else begin : g_double
            always_comb m_axis_result_tdata = dp_addsub(stg_a[LAST], stg_b[LAST], stg_sub[LAST]);
        end
    endgenerate

`ifdef FLOAT_ADDSUB_STREAM_FLAGS_EN
    localparam int EXP_W  = (SIZE == 64) ? 11 : 8;
    localparam int FRAC_W = SIZE - EXP_W - 1;

    function automatic logic exp_max(input logic [SIZE-1:0] x);
        return &x[SIZE-2:FRAC_W];
    endfunction

    function automatic logic is_nan(input logic [SIZE-1:0] x);
        return exp_max(x) & (|x[FRAC_W-1:0]);
    endfunction

    function automatic logic is_zero(input logic [SIZE-1:0] x);
        return ~|x[SIZE-2:0];
    endfunction

    // Flags are derived from the operands and result of the beat currently presented.
    always_comb begin
        m_axis_result_flags    = '0;
        m_axis_result_flags[0] = is_nan(stg_a[LAST]) | is_nan(stg_b[LAST]) | is_nan(m_axis_result_tdata);
        m_axis_result_flags[1] = ~exp_max(stg_a[LAST]) & ~exp_max(stg_b[LAST])
                                 & exp_max(m_axis_result_tdata) & ~is_nan(m_axis_result_tdata);
        m_axis_result_flags[2] = ~exp_max(stg_a[LAST]) & ~exp_max(stg_b[LAST])
                                 & ~is_zero(stg_a[LAST]) & ~is_zero(stg_b[LAST])
                                 & ~|m_axis_result_tdata[SIZE-2:FRAC_W];
    end
`endif

endmodule

// File: doc/float_addsub_stream.md
Name: float_addsub_stream

Overview:
- Parametrised simulation model of a floating-point adder/subtractor with AXI-Stream interfaces. Successor to the fixed-latency float add model.
- Three-way input join: A operand, B operand, operation select.
- Configurable precision (32/64) and latency; per-stage pipeline with bubble collapsing; user sideband passthrough.
- Sits in the sim tree as a stand-in for the vendor floating-point core in datapath testbenches.

Parameters:
- SIZE, 32, operand/result width; legal values 32 (single, shortreal) and 64 (double, real). Any other value is a fatal elaboration error.
- LATENCY, 12, cycles from input accept to result valid with no backpressure; legal range 1 to 64.
- USER_W, 8, width of the tuser sideband carried from channel A to the result.

Ports:
- aclk  in  1  clock, all logic on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_a_tdata  in  SIZE  operand A bit pattern.
- s_axis_a_tuser  in  USER_W  sideband, returned unchanged with the result.
- s_axis_a_tvalid  in  1  A valid.
- s_axis_a_tready  out  1  A ready.
- s_axis_b_tdata  in  SIZE  operand B bit pattern.
- s_axis_b_tvalid  in  1  B valid.
- s_axis_b_tready  out  1  B ready.
- s_axis_operation_tdata  in  8  bit0: 0 = add, 1 = subtract (A-B); bits 7:1 ignored.
- s_axis_operation_tvalid  in  1  operation valid.
- s_axis_operation_tready  out  1  operation ready.
- m_axis_result_tdata  out  SIZE  result bit pattern.
- m_axis_result_tuser  out  USER_W  sideband of the producing A beat.
- m_axis_result_tvalid  out  1  result valid.
- m_axis_result_tready  in  1  downstream ready.

Behaviour:
- Reset: asynchronous, active-low. While aresetn=0, all stage valid bits clear, m_axis_result_tvalid=0, all three s_*_tready=0. Data registers are not reset.
- Pipeline: LATENCY stages, each holding data, sideband and a valid bit. Output is the last stage.
- Stage k advance: stage k loads from stage k-1 when stage k is empty or stage k is itself advancing. The last stage advances when m_axis_result_tready=1 or it is empty.
- Bubbles collapse: a downstream stall does not block upstream stages that have empty slots ahead of them.
- Join: a beat is accepted only when all three inputs are valid and stage 0 can load. All three tready outputs are driven equal to (stage0 can load) AND a_tvalid AND b_tvalid AND op_tvalid. Partial valids never consume data.
- Latency: a beat accepted at edge N presents on m_axis_result_tvalid after edge N+LATENCY-1 when no stall occurs. Throughput is 1 beat per cycle sustained.
- AXI rules: once m_axis_result_tvalid=1, tdata/tuser/tvalid hold stable until the tready handshake. Valid and data never drop without a handshake.
- Arithmetic: computed in the last stage.
  - SIZE=32: $shortrealtobits($bitstoshortreal(a) op $bitstoshortreal(b)).
  - SIZE=64: $realtobits($bitstoreal(a) op $bitstoreal(b)).
  - Rounding is the simulator's (round-to-nearest-even). NaN results are forced to canonical quiet NaN: 0x7FC00000 (32) or 0x7FF8000000000000 (64).
- Simultaneous accept and drain in one cycle is legal at full occupancy: the pipe stays full and no beat is lost.
- Reset mid-stream: all in-flight beats are discarded. After release, the first result is the first beat accepted after release.

Optional Feature:
- Macro: FLOAT_ADDSUB_STREAM_FLAGS_EN.
- Defined: adds port m_axis_result_flags, out, 3 bits, aligned with tdata.
  - bit0 invalid: inf-inf or NaN input.
  - bit1 overflow: finite inputs, infinite result.
  - bit2 underflow: nonzero exact operands giving a zero or subnormal result.
- Not defined: the port is absent and no flag logic is compiled.

Test Plan:
- Add: A=0x3FC00000, B=0x40100000, op=0, ready held 1 -> result 0x40700000 with tvalid exactly LATENCY-1 edges after accept; tuser=0x5A returned as 0x5A.
- Subtract: A=0x3F800000, B=0x40400000, op=1 -> result 0xC0000000.
- Join: A and op valid for 4 cycles, B low -> all treadys low and no accept. Raise B -> one accept, one result.
- Backpressure: 40 back-to-back beats (A=i, B=1.0) with result tready low for cycles 10-17 -> all 40 results in order, values exact, no duplicates or drops, tdata stable while stalled, full throughput outside the stall.
- Reset mid-stream: assert aresetn=0 asynchronously with 5 beats in flight -> tvalid low immediately. After release, the next accepted beat (1.0+1.0) yields 0x40000000 as the first result.
- Flags (macro defined): A=B=0x7F800000, op=1 -> 0x7FC00000 with invalid=1. A=B=0x7F7FFFFF, op=0 -> 0x7F800000 with overflow=1.
